stereolbm_axis_cambm_deadlock_reporter: RTL and testbench
=========================================================

// Module: stereolbm_axis_cambm_deadlock_reporter
// PURPOSE
//  Consumer of the top-level HLS deadlock monitor's one-bit block output, inside the stereo LBM core.
//  - Qualifies block_in: it must stay high for a programmable number of consecutive cycles.
//  - Then latches a sticky deadlock flag and raises a one-cycle interrupt.
//  - Captures a snapshot of per-process stop and AXIS-stall status, plus a timestamp.
//  - Counts deadlock events for software debug of the stereo dataflow pipeline.
// PARAMETERS
//  N_PROC   17  number of dataflow processes in the proc_stop_vec snapshot
//  N_AXIS   7   number of AXIS stall signals in the axis_block_sigs snapshot
//  CNT_W    16  width of the qualification run counter and of cfg_threshold
//  TS_W     32  width of the free-running timestamp counter
// PORTS
//  clock            in   1       single clock domain; all logic on posedge
//  reset            in   1       asynchronous, active-high reset
//  block_in         in   1       block output of the deadlock monitor
//  proc_stop_vec    in   N_PROC  per-process idle|chan_block|axis_block status
//  axis_block_sigs  in   N_AXIS  raw AXIS stall signals
//  cfg_enable       in   1       1 = detection armed
//  cfg_threshold    in   CNT_W   consecutive block_in cycles required; 0 is treated as 1
//  clear_pulse      in   1       one-cycle software acknowledge
//  deadlock_flag    out  1       sticky; high while in DEADLOCK
//  deadlock_irq     out  1       one-cycle pulse on entry to DEADLOCK
//  state_o          out  2       IDLE=0, SUSPECT=1, DEADLOCK=2 (3 unused; treated as IDLE)
//  snap_proc_vec    out  N_PROC  proc_stop_vec captured at detection
//  snap_axis_vec    out  N_AXIS  axis_block_sigs captured at detection
//  snap_timestamp   out  TS_W    timestamp captured at detection
//  event_count      out  8       number of DEADLOCK entries; saturates at 255
// BEHAVIOUR
//  Reset (async): all outputs and registers go to 0, state=IDLE, timestamp=0.
//  Timestamp: ts increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
//  Run counter: run_cnt holds the number of consecutive qualifying cycles.
//    - A qualifying cycle has cfg_enable=1, block_in=1 and clear_pulse=0.
//    - run_cnt saturates at 2^CNT_W-1.
//    - Let T = max(cfg_threshold,1), sampled every cycle.
//  IDLE:
//    - On a qualifying cycle: if T==1 go to DEADLOCK, else go to SUSPECT with run_cnt=1.
//    - Otherwise stay in IDLE with run_cnt=0.
//  SUSPECT:
//    - On a non-qualifying cycle: go to IDLE, run_cnt=0.
//    - On a qualifying cycle with run_cnt+1 >= T: go to DEADLOCK.
//    - On any other qualifying cycle: run_cnt += 1.
//    - Lowering cfg_threshold mid-run takes effect on the next compare.
//  Detection cycle: the last qualifying cycle, at the clock edge where the transition to DEADLOCK is taken.
//    - snap_proc_vec, snap_axis_vec and snap_timestamp capture that cycle's proc_stop_vec, axis_block_sigs and ts.
//    - event_count increments (saturating).
//    - Next cycle: deadlock_flag=1 and deadlock_irq=1, for exactly one cycle of irq.
//    - Latency: with block_in high from cycle 0, deadlock_flag rises in cycle T.
//  DEADLOCK:
//    - The state is held regardless of block_in and cfg_enable; only clear_pulse exits.
//    - On clear_pulse: go to IDLE, run_cnt=0; deadlock_flag=0 the next cycle.
//    - The clear cycle never counts as qualifying. Re-entry needs T fresh qualifying cycles.
//  clear_pulse in IDLE or SUSPECT: aborts the run (run_cnt=0, go to IDLE).
//  Snapshots and event_count are never altered by clear_pulse; they persist until the next detection or reset.
//  Reset mid-run: asserting reset during SUSPECT or DEADLOCK immediately returns every register and output to its reset value.
//  deadlock_irq never asserts in two consecutive cycles.
// TESTING
//  T1 cfg_threshold=4, block_in high for cycles 0..5, ts=0 at cycle 0:
//     flag and irq rise at cycle 4; irq low at 5; snap_timestamp=3; event_count=1.
//  T2 T=4, block_in high for cycles 0..2, low at 3, then high for 4..7:
//     cycles 0..3 give no detection; flag rises at cycle 8.
//  T3 cfg_threshold=0 with a single block_in pulse at cycle 10:
//     flag rises at 11; snap_proc_vec equals proc_stop_vec driven at cycle 10 (e.g. 17'h1FFFF).
//  T4 In DEADLOCK, clear_pulse with block_in held high, T=2:
//     state_o=0 the next cycle; flag re-rises 3 cycles after the clear cycle; event_count=2.
//  T5 Force 256 detect/clear cycles -> event_count stays at 255.
//     Start ts at 2^TS_W-2 -> ts wraps to 0 with no glitch on the state.
//  T6 Async reset asserted mid-SUSPECT (run_cnt=3) and again in DEADLOCK, off a clock edge:
//     all outputs 0 immediately; cfg_enable=0 in SUSPECT returns to IDLE.

Source files
------------

// File: rtl/stereolbm_axis_cambm_deadlock_reporter.sv
// Qualifies the HLS deadlock monitor's block output over a programmable run length, then latches a
// sticky deadlock flag, pulses an interrupt and snapshots process/AXIS stall status with a timestamp.
module stereolbm_axis_cambm_deadlock_reporter #(
    parameter int N_PROC = 17,
    parameter int N_AXIS = 7,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [N_PROC-1:0] proc_stop_vec,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic              cfg_enable,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic              clear_pulse,
    output logic              deadlock_flag,
    output logic              deadlock_irq,
    output logic [1:0]        state_o,
    output logic [N_PROC-1:0] snap_proc_vec,
    output logic [N_AXIS-1:0] snap_axis_vec,
    output logic [TS_W-1:0]   snap_timestamp,
    output logic [7:0]        event_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  run_q;
    logic [CNT_W-1:0]  run_d;
    logic [CNT_W-1:0]  thr_eff;
    logic [CNT_W:0]    run_inc;
    logic [CNT_W-1:0]  run_sat;
    logic              qualify;
    logic              detect;
    logic              irq_q;
    logic [TS_W-1:0]   ts_q;

    // A clear cycle is never a qualifying cycle, even while block_in stays high.
    assign qualify = cfg_enable & block_in & ~clear_pulse;
    assign thr_eff = (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;
    assign run_inc = {1'b0, run_q} + {{CNT_W{1'b0}}, 1'b1};
    assign run_sat = run_inc[CNT_W] ? {CNT_W{1'b1}} : run_inc[CNT_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // The encoding 2'b11 is unreachable and falls into the default (IDLE) branch.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        detect  = 1'b0;
        case (state_q)
            ST_SUSPECT: begin
                if (!qualify) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else if (run_inc >= {1'b0, thr_eff}) begin
                    state_d = ST_DEADLOCK;
                    run_d   = run_sat;
                    detect  = 1'b1;
                end else begin
                    run_d = run_sat;
                end
            end
            ST_DEADLOCK: begin
                if (clear_pulse) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
                if (qualify) begin
                    run_d = CNT_W'(1);
                    if (thr_eff == CNT_W'(1)) begin
                        state_d = ST_DEADLOCK;
                        detect  = 1'b1;
                    end else begin
                        state_d = ST_SUSPECT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Snapshots and the event counter only move on detection; clear_pulse leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q          <= 1'b0;
            snap_proc_vec  <= '0;
            snap_axis_vec  <= '0;
            snap_timestamp <= '0;
            event_count    <= '0;
        end else begin
            irq_q <= detect;
            if (detect) begin
                snap_proc_vec  <= proc_stop_vec;
                snap_axis_vec  <= axis_block_sigs;
                snap_timestamp <= ts_q;
                if (event_count != 8'hFF) begin
                    event_count <= event_count + 8'd1;
                end
            end
        end
    end

    assign deadlock_flag = (state_q == ST_DEADLOCK);
    assign deadlock_irq  = irq_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_deadlock_reporter.sv
// Directed bench: detection cycles push expected snapshots into a queue that an irq-driven monitor checks.
module tb_stereolbm_axis_cambm_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        block_in = 1'b0;
    logic [16:0] proc_stop_vec = '0;
    logic [6:0]  axis_block_sigs = '0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_threshold = '0;
    logic        clear_pulse = 1'b0;
    logic        deadlock_flag;
    logic        deadlock_irq;
    logic [1:0]  state_o;
    logic [16:0] snap_proc_vec;
    logic [6:0]  snap_axis_vec;
    logic [31:0] snap_timestamp;
    logic [7:0]  event_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_ts;
    logic [7:0]  exp_events = '0;
    logic [63:0] exp_q[$];
    logic        prev_irq = 1'b0;

    stereolbm_axis_cambm_deadlock_reporter dut (
        .clock(clock), .reset(reset), .block_in(block_in), .proc_stop_vec(proc_stop_vec),
        .axis_block_sigs(axis_block_sigs), .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold),
        .clear_pulse(clear_pulse), .deadlock_flag(deadlock_flag), .deadlock_irq(deadlock_irq),
        .state_o(state_o), .snap_proc_vec(snap_proc_vec), .snap_axis_vec(snap_axis_vec),
        .snap_timestamp(snap_timestamp), .event_count(event_count)
    );

    always #5 clock = ~clock;

    // Reference timestamp: counts cycles since reset release.
    always @(posedge clock or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; det marks the cycle expected to be the detection cycle.
    task automatic cyc(input logic blk, input logic clr, input logic det);
        block_in    = blk;
        clear_pulse = clr;
        if (det) begin
            exp_events = (exp_events == 8'hFF) ? 8'hFF : exp_events + 8'd1;
            exp_q.push_back({proc_stop_vec, axis_block_sigs, tb_ts, exp_events});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_state"}, 64'(state_o), 64'd0);
        chk({name, "_flag"}, 64'(deadlock_flag), 64'd0);
        chk({name, "_irq"}, 64'(deadlock_irq), 64'd0);
        chk({name, "_snaps"}, {snap_proc_vec, snap_axis_vec, snap_timestamp, event_count}, 64'd0);
    endtask

    task automatic do_reset();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        reset       = 1'b1;
        block_in    = 1'b0;
        clear_pulse = 1'b0;
        exp_events  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every irq pulse must match the next expected snapshot.
    always @(negedge clock) begin
        if (!reset) begin
            if (deadlock_irq) begin
                checks++;
                if (prev_irq) begin
                    errors++;
                    $display("FAIL irq_back_to_back: got 1 expected 0");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL irq_unexpected: got irq expected none");
                end else begin
                    logic [63:0] e;
                    logic [63:0] g;
                    e = exp_q.pop_front();
                    g = {snap_proc_vec, snap_axis_vec, snap_timestamp, event_count};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL irq_snapshot: got %016h expected %016h", g, e);
                    end
                end
            end
            prev_irq = deadlock_irq;
        end else begin
            prev_irq = 1'b0;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // T1 + T4: threshold 4 detection, then clear and re-detect with threshold 2
        cfg_enable = 1'b1; cfg_threshold = 16'd4;
        proc_stop_vec = 17'h0A5A5; axis_block_sigs = 7'h3C;
        cyc(1, 0, 0); chk("t1_c0_state", 64'(state_o), 64'd1);
        cyc(1, 0, 0); cyc(1, 0, 0);
        chk("t1_c2_state", 64'(state_o), 64'd1);
        chk("t1_c2_flag", 64'(deadlock_flag), 64'd0);
        cyc(1, 0, 1);
        chk("t1_c4_flag", 64'(deadlock_flag), 64'd1);
        chk("t1_c4_irq", 64'(deadlock_irq), 64'd1);
        chk("t1_c4_state", 64'(state_o), 64'd2);
        chk("t1_snap_ts", 64'(snap_timestamp), 64'd3);
        chk("t1_count", 64'(event_count), 64'd1);
        cyc(1, 0, 0);
        chk("t1_c5_irq", 64'(deadlock_irq), 64'd0);
        chk("t1_c5_flag", 64'(deadlock_flag), 64'd1);
        cfg_threshold = 16'd2;
        cyc(1, 1, 0);
        chk("t4_clear_state", 64'(state_o), 64'd0);
        chk("t4_clear_flag", 64'(deadlock_flag), 64'd0);
        chk("t4_snap_kept", 64'(snap_timestamp), 64'd3);
        proc_stop_vec = 17'h13579; axis_block_sigs = 7'h41;
        cyc(1, 0, 0); chk("t4_suspect", 64'(state_o), 64'd1);
        cyc(1, 0, 1);
        chk("t4_reflag", 64'(deadlock_flag), 64'd1);
        chk("t4_count", 64'(event_count), 64'd2);
        cyc(0, 1, 0);

        // T2: broken run restarts qualification
        do_reset();
        cfg_threshold = 16'd4; proc_stop_vec = 17'h00F0F; axis_block_sigs = 7'h12;
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(0, 0, 0); chk("t2_break_state", 64'(state_o), 64'd0);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("t2_c7_state", 64'(state_o), 64'd1);
        chk("t2_c7_flag", 64'(deadlock_flag), 64'd0);
        cyc(1, 0, 1); chk("t2_c8_flag", 64'(deadlock_flag), 64'd1);
        cyc(0, 1, 0);

        // T3: threshold 0 acts as 1; DEADLOCK holds with enable low
        do_reset();
        cfg_threshold = 16'd0; proc_stop_vec = 17'h00000;
        repeat (10) cyc(0, 0, 0);
        proc_stop_vec = 17'h1FFFF; axis_block_sigs = 7'h55;
        cyc(1, 0, 1);
        chk("t3_flag", 64'(deadlock_flag), 64'd1);
        chk("t3_snap_proc", 64'(snap_proc_vec), 64'h1FFFF);
        chk("t3_snap_ts", 64'(snap_timestamp), 64'd10);
        proc_stop_vec = 17'h0; cfg_enable = 1'b0;
        cyc(0, 0, 0); chk("t3_hold", 64'(state_o), 64'd2);
        cyc(0, 1, 0); chk("t3_clear", 64'(state_o), 64'd0);
        cfg_enable = 1'b1;

        // T6: asynchronous reset in SUSPECT and in DEADLOCK, enable drop in SUSPECT
        do_reset();
        cfg_threshold = 16'd2; proc_stop_vec = 17'h0BEEF; axis_block_sigs = 7'h7F;
        cyc(1, 0, 0); cyc(1, 0, 1); cyc(0, 0, 0); cyc(0, 1, 0);
        cfg_threshold = 16'd8;
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("t6_suspect", 64'(state_o), 64'd1);
        chk("t6_count_pre", 64'(event_count), 64'd1);
        chk("queue_before_async", 64'(exp_q.size()), 64'd0);
        #2 reset = 1'b1; exp_events = '0;
        #1 chk_all_zero("t6_rst_suspect");
        @(posedge clock); #1 reset = 1'b0;
        cfg_threshold = 16'd1;
        cyc(1, 0, 1); cyc(0, 0, 0);
        chk("t6_deadlock", 64'(state_o), 64'd2);
        chk("queue_before_async2", 64'(exp_q.size()), 64'd0);
        #2 reset = 1'b1; exp_events = '0;
        #1 chk_all_zero("t6_rst_deadlock");
        @(posedge clock); #1 reset = 1'b0;
        cfg_threshold = 16'd8;
        cyc(1, 0, 0); cyc(1, 0, 0);
        cfg_enable = 1'b0;
        cyc(1, 0, 0); chk("t6_disable", 64'(state_o), 64'd0);
        cfg_enable = 1'b1;

        // T5: event counter saturation over repeated detect/clear
        do_reset();
        cfg_threshold = 16'd0;
        for (int i = 0; i < 260; i++) begin
            proc_stop_vec = 17'($urandom);
            axis_block_sigs = 7'($urandom_range(0, 127));
            cyc(1, 0, 1);
            cyc(0, 1, 0);
        end
        chk("t5_saturate", 64'(event_count), 64'd255);
        cyc(0, 0, 0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
